// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: datapath width, default boot address and
// the canonical NOP (addi x0, x0, 0) presented when no instruction is valid.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus: the fetch unit drives request/address and the
// synchronous memory returns data one cycle after each request.
interface instr_fetch_unit_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            req;
  logic [XLEN-1:0] addr;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Output register plus one skid entry between instruction memory and decode.
// The output always holds the oldest instruction; flush drops both entries.
module fetch_skid_buffer #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            in_valid_i,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  output logic [31:0]     out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic            skid_valid_o
);

  import riscv_pkg::*;

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            deq;

  assign deq = out_valid_q & ~stall_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      // The PC is kept so decode still sees the last address while invalid
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || deq) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) begin
          skid_instr_d = in_instr_i;
          skid_pc_d    = in_pc_i;
        end
      end else if (in_valid_i) begin
        out_valid_d = 1'b1;
        out_instr_d = in_instr_i;
        out_pc_d    = in_pc_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr_i;
      skid_pc_d    = in_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= INSTR_NOP;
      out_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= INSTR_NOP;
      skid_pc_q    <= RESET_PC;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_instr_o  = out_valid_q ? out_instr_q : INSTR_NOP;
  assign out_pc_o     = out_pc_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC and in-flight tracking, issues one read per
// cycle while downstream storage can absorb it, and squashes on redirect.
module instr_fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                stall_i,
  input  logic                redirect_valid_i,
  input  logic [XLEN-1:0]     redirect_target_i,
  output logic                instr_valid_o,
  output logic [31:0]         instr_o,
  output logic [XLEN-1:0]     instr_pc_o,
  output logic [XLEN-1:0]     instr_pc_plus4_o
);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            infl_q, infl_d;
  logic            skid_valid;
  logic            deq;
  logic [1:0]      occ;
  logic            req;

  assign deq = instr_valid_o & ~stall_i;
  assign occ = 2'(instr_valid_o) + 2'(skid_valid) + 2'(infl_q);

  // A new read is allowed only if, after this cycle's dequeue, one slot
  // remains free for the word it will return; the fetch stalls before overflow.
  assign req = ~rst & ~redirect_valid_i & ((occ - 2'(deq)) <= 2'd1);

  assign imem.req  = req;
  assign imem.addr = fpc_q;

  always_comb begin
    fpc_d     = fpc_q;
    infl_d    = req;
    infl_pc_d = infl_pc_q;
    if (redirect_valid_i) begin
      fpc_d = redirect_target_i & ~XLEN'(3);
    end else if (req) begin
      fpc_d     = fpc_q + XLEN'(4);
      infl_pc_d = fpc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q     <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= RESET_PC;
    end else begin
      fpc_q     <= fpc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  fetch_skid_buffer #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid_i),
    .stall_i      (stall_i),
    .in_valid_i   (infl_q & ~redirect_valid_i),
    .in_instr_i   (imem.rdata),
    .in_pc_i      (infl_pc_q),
    .out_valid_o  (instr_valid_o),
    .out_instr_o  (instr_o),
    .out_pc_o     (instr_pc_o),
    .skid_valid_o (skid_valid)
  );

  assign instr_pc_plus4_o = instr_pc_o + XLEN'(4);

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Pipelined instruction fetch stage directly upstream of the main decoder. Generates the fetch PC, issues reads to a synchronous instruction memory with one-cycle read latency, and presents one instruction per cycle (instr, PC, PC+4) with a valid flag to decode. Absorbs decode back-pressure with a one-entry skid buffer and squashes in-flight fetches on a branch/jump redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- XLEN, 32, address/data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  read request this cycle
- imem_addr  out  XLEN  read address, word aligned
- imem_rdata  in  32  read data, valid the cycle after imem_req=1 (memory always accepts)
- stall  in  1  decode cannot accept; hold current output
- redirect_valid  in  1  taken branch or JAL resolved this cycle
- redirect_target  in  XLEN  new fetch address
- instr_valid  out  1  instr/instr_pc/instr_pc_plus4 are meaningful
- instr  out  32  instruction word; instr[6:0] is the decoder opcode
- instr_pc  out  XLEN  address of instr
- instr_pc_plus4  out  XLEN  instr_pc + 4 (return address for JAL)

## Operation
- State: fetch PC fpc; in-flight flag infl with its PC infl_pc; output register (instr_valid, instr, instr_pc); skid entry (skid_valid, skid_instr, skid_pc).
- deq = instr_valid & ~stall. occ = instr_valid + skid_valid + infl (0..3, never exceeds 2 after reset).
- imem_req = ~redirect_valid & (occ - deq <= 1). imem_addr = fpc. On request: fpc <= fpc + 4, infl <= 1, infl_pc <= fpc; otherwise infl <= 0.
- Response (infl=1) routing: if output register empty or deq -> written to output register (when skid_valid, skid moves to output and response goes to skid); else -> skid.
- On deq with skid_valid: skid entry moves to output register, skid cleared.
- Order preserved: output always holds the oldest instruction.
- Redirect (priority over stall and everything else): next cycle instr_valid=0, skid_valid=0, infl response of this cycle discarded, fpc <= {redirect_target[XLEN-1:2], 2'b00}, imem_req=0 this cycle.
- When instr_valid=0, instr drives NOP 32'h0000_0013; instr_pc/instr_pc_plus4 hold last value.
- Arithmetic modulo 2^XLEN: fpc 32'hFFFF_FFFC + 4 -> 32'h0000_0000.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4, skid_valid=0, infl=0, fpc=RESET_PC.
- First request in first cycle after rst falls; first instr_valid two cycles later.
- Latency request -> instr_valid: 2 cycles. Redirect in cycle t -> request to target in t+1 -> instr_valid at target in t+3.
- Throughput: 1 instruction/cycle with stall=0.
- stall=1 for N cycles: outputs stable; at most 2 fetches pending (output + skid), no requests beyond that; after stall falls, consecutive valid instructions, no bubble, no loss, no duplication.
- Simultaneous stall and redirect: redirect wins, output invalidated.
- rst asserted mid-operation: all state to reset values immediately; pending memory data ignored.

## Structure
- Shared package riscv_pkg: XLEN, RESET_PC default, INSTR_NOP = 32'h0000_0013.
- Sub-module fetch_skid_buffer: output register + skid entry, valid/stall handshake, flush input; top level holds fpc, request logic and in-flight tracking.

## Test plan
- Reset release, stall=0, memory word = address: instr_valid high from cycle 2, instr_pc 0,4,8,... every cycle, instr_pc_plus4 = instr_pc+4.
- stall=1 for 5 cycles at instr_pc=0x10: outputs frozen at 0x10, imem_req low after 2 pending, after release sequence 0x10,0x14,0x18 without gaps or repeats.
- redirect_valid with target 0x100 at cycle t: instr_valid=0 at t+1,t+2; instr_pc=0x100 valid at t+3; no instruction from old stream appears.
- redirect with target 0x203 while stall=1 and skid full: buffer flushed, next valid instr_pc=0x200.
- RESET_PC=32'hFFFF_FFF8: instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst pulsed mid-stream with skid full: outputs return to reset values asynchronously; fetch restarts at RESET_PC.
